// File: rtl/lms_pkg.sv
// Shared parameters and types for the LMS coefficient-update engine.
package lms_pkg;

   localparam int unsigned NTAPS    = 16;
   localparam int unsigned XW       = 14;
   localparam int unsigned WW       = 32;
   localparam int unsigned MU_SHIFT = 10;
   localparam int unsigned IDXW     = $clog2(NTAPS);
   localparam int unsigned PW       = WW + XW;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef logic signed [WW-1:0] weight_t;
   typedef logic signed [XW-1:0] xsamp_t;

endpackage

// File: rtl/lms_tap_update.sv
// One LMS tap step: w + ((e * x) >>> SHIFT), wrapped or clamped to WW bits.
// Build option: define LMS_WEIGHT_SAT_EN to saturate instead of wrap.
module lms_tap_update
   import lms_pkg::*;
#(
   parameter int unsigned SHIFT = MU_SHIFT
) (
   input  logic signed [WW-1:0] w_i,
   input  logic signed [WW-1:0] e_i,
   input  logic signed [XW-1:0] x_i,
   output logic signed [WW-1:0] w_o
);

   logic signed [PW-1:0] prod;
   logic signed [WW:0]   step;
   logic signed [WW:0]   sum;

   // Full-precision product; arithmetic shift floors toward -infinity.
   always_comb begin
      prod = PW'(e_i) * PW'(x_i);
      step = (WW+1)'(prod >>> SHIFT);
      sum  = {w_i[WW-1], w_i} + step;
   end

`ifdef LMS_WEIGHT_SAT_EN
   always_comb begin
      w_o = sum[WW-1:0];
      if (sum[WW] != sum[WW-1]) begin
         w_o = sum[WW] ? {1'b1, {(WW-1){1'b0}}} : {1'b0, {(WW-1){1'b1}}};
      end
   end
`else
   assign w_o = sum[WW-1:0];
`endif

endmodule

// File: rtl/lms_weight_update.sv
// LMS weight-update engine: one tap per clock through a shared MAC, start/busy/done framed.
// Build option: LMS_WEIGHT_SAT_EN selects saturating instead of wrapping weight updates.
module lms_weight_update
   import lms_pkg::*;
(
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   clear,
   input  logic [WW-1:0]          e_in,
   input  logic [NTAPS*XW-1:0]    ref_bus,
   output logic [NTAPS*WW-1:0]    weight_bus,
   output logic                   busy,
   output logic                   done
);

   state_e              state_q;
   logic [IDXW-1:0]     idx_q;
   logic [WW-1:0]       e_q;
   logic [NTAPS*XW-1:0] x_q;
   logic [NTAPS*WW-1:0] w_q;
   logic                busy_q;
   logic                done_q;

   weight_t w_cur;
   xsamp_t  x_cur;
   weight_t w_nxt;

   // Select the tap addressed by the pass index.
   always_comb begin
      w_cur = w_q[idx_q*WW +: WW];
      x_cur = x_q[idx_q*XW +: XW];
   end

   lms_tap_update #(
      .SHIFT (MU_SHIFT)
   ) u_tap (
      .w_i (w_cur),
      .e_i (e_q),
      .x_i (x_cur),
      .w_o (w_nxt)
   );

   // Pass sequencer, input latches and weight register file.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         e_q     <= '0;
         x_q     <= '0;
         w_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (clear) begin
         state_q <= IDLE;
         idx_q   <= '0;
         w_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  e_q     <= e_in;
                  x_q     <= ref_bus;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= UPDATE;
               end
            end
            UPDATE: begin
               w_q[idx_q*WW +: WW] <= w_nxt;
               if (idx_q == IDXW'(NTAPS-1)) begin
                  idx_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + IDXW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign weight_bus = w_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_lms_weight_update.sv
// Self-checking bench for lms_weight_update: table of update passes plus handshake/abort sequences.
module tb_lms_weight_update;
   import lms_pkg::*;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                start = 1'b0;
   logic                clear = 1'b0;
   logic [WW-1:0]       e_in = '0;
   logic [NTAPS*XW-1:0] ref_bus = '0;
   logic [NTAPS*WW-1:0] weight_bus;
   logic                busy;
   logic                done;

   int n_checks = 0;
   int n_fail   = 0;

   logic [NTAPS*WW-1:0] sb_q[$];

`ifdef LMS_WEIGHT_SAT_EN
   localparam logic [WW-1:0] W_OVF = 32'h7FFF_FFFF;
`else
   localparam logic [WW-1:0] W_OVF = 32'h8000_00F0;
`endif

   typedef struct packed {
      logic                clr;
      logic [WW-1:0]       e;
      logic [NTAPS*XW-1:0] x;
      logic [NTAPS*WW-1:0] w;
   } vec_t;

   localparam int NVEC = 9;
   vec_t vecs [NVEC];

   lms_weight_update dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .clear      (clear),
      .e_in       (e_in),
      .ref_bus    (ref_bus),
      .weight_bus (weight_bus),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [NTAPS*WW-1:0] act, input logic [NTAPS*WW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_i(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [NTAPS*XW-1:0] taps1(input int k, input logic [XW-1:0] v);
      logic [NTAPS*XW-1:0] r;
      r = '0;
      r[k*XW +: XW] = v;
      return r;
   endfunction

   function automatic logic [NTAPS*XW-1:0] taps_all(input logic [XW-1:0] v);
      logic [NTAPS*XW-1:0] r;
      for (int k = 0; k < NTAPS; k++) r[k*XW +: XW] = v;
      return r;
   endfunction

   function automatic logic [NTAPS*XW-1:0] taps_rand();
      logic [NTAPS*XW-1:0] r;
      for (int k = 0; k < NTAPS; k++) r[k*XW +: XW] = XW'($urandom);
      return r;
   endfunction

   function automatic logic [NTAPS*WW-1:0] wts1(input int k, input logic [WW-1:0] v);
      logic [NTAPS*WW-1:0] r;
      r = '0;
      r[k*WW +: WW] = v;
      return r;
   endfunction

   function automatic logic [NTAPS*WW-1:0] wts_all(input logic [WW-1:0] v);
      logic [NTAPS*WW-1:0] r;
      for (int k = 0; k < NTAPS; k++) r[k*WW +: WW] = v;
      return r;
   endfunction

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // mode 0: plain pass; 1: re-pulse start and scramble inputs mid-pass; 2: clear mid-pass
   task automatic run_pass(input string nm, input logic [WW-1:0] e, input logic [NTAPS*XW-1:0] x,
                           input logic [NTAPS*WW-1:0] exp, input int mode);
      int lat;
      int bcnt;
      int dcnt;
      lat  = -1;
      bcnt = 0;
      dcnt = 0;
      if (mode != 2) sb_q.push_back(exp);
      @(negedge clk);
      e_in    = e;
      ref_bus = x;
      start   = 1'b1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (k == 0) begin
            start   = 1'b0;
            e_in    = $urandom;
            ref_bus = taps_rand();
         end
         if (mode == 1 && k == 4) begin
            start   = 1'b1;
            e_in    = $urandom;
            ref_bus = taps_rand();
         end
         if (mode == 1 && k == 5) start = 1'b0;
         if (mode == 2 && k == 7) clear = 1'b1;
         if (mode == 2 && k == 8) clear = 1'b0;
         if (busy) bcnt++;
         if (done) begin
            dcnt++;
            if (lat < 0) lat = k;
            if (sb_q.size() > 0) chk({nm, "_weights"}, weight_bus, sb_q.pop_front());
         end
      end
      if (mode == 2) begin
         chk_i({nm, "_done_count"}, dcnt, 0);
         chk({nm, "_weights"}, weight_bus, '0);
         chk_i({nm, "_busy"}, int'(busy), 0);
      end else begin
         chk_i({nm, "_done_count"}, dcnt, 1);
         chk_i({nm, "_busy_cycles"}, bcnt, 16);
         if (mode == 0) chk_i({nm, "_done_latency"}, lat, 16);
      end
      sb_q.delete();
   endtask

   initial begin
      int dcnt;

      vecs[0] = '{clr: 1'b1, e: 32'd1024,        x: taps1(0, 14'd1),    w: wts1(0, 32'd1)};
      vecs[1] = '{clr: 1'b1, e: 32'(-2048),      x: taps_all(14'd3),    w: wts_all(32'(-6))};
      vecs[2] = '{clr: 1'b0, e: 32'(-2048),      x: taps_all(14'd3),    w: wts_all(32'(-12))};
      vecs[3] = '{clr: 1'b1, e: 32'(-1),         x: taps1(5, 14'd1),    w: wts1(5, 32'(-1))};
      vecs[4] = '{clr: 1'b1, e: 32'h7FFF_FFF0,   x: taps1(3, 14'd1024), w: wts1(3, 32'h7FFF_FFF0)};
      vecs[5] = '{clr: 1'b0, e: 32'h0004_0000,   x: taps1(3, 14'd1),    w: wts1(3, W_OVF)};
      vecs[6] = '{clr: 1'b0, e: 32'd0,           x: taps_all(14'd7),    w: wts1(3, W_OVF)};
      vecs[7] = '{clr: 1'b1, e: 32'd5,           x: taps1(2, 14'h3FFF) | taps1(7, 14'd1000),
                  w: wts1(2, 32'(-1)) | wts1(7, 32'd4)};
      vecs[8] = '{clr: 1'b0, e: 32'(-3000),      x: taps1(9, 14'h3FFB),
                  w: wts1(2, 32'(-1)) | wts1(7, 32'd4) | wts1(9, 32'd14)};

      repeat (3) @(negedge clk);
      chk("reset_weights", weight_bus, '0);
      chk_i("reset_busy", int'(busy), 0);
      chk_i("reset_done", int'(done), 0);
      rstn = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         if (vecs[i].clr) do_clear();
         run_pass($sformatf("vec%0d", i), vecs[i].e, vecs[i].x, vecs[i].w, 0);
      end

      do_clear();
      run_pass("midpass_restart", 32'(-2048), taps_all(14'd3), wts_all(32'(-6)), 1);
      run_pass("clear_midpass", 32'(-2048), taps_all(14'd3), '0, 2);
      run_pass("after_clear", 32'd1024, taps1(0, 14'd1), wts1(0, 32'd1), 0);

      // clear and start on the same edge: clear wins
      @(negedge clk);
      clear   = 1'b1;
      start   = 1'b1;
      e_in    = 32'd1024;
      ref_bus = taps_all(14'd1);
      @(negedge clk);
      clear = 1'b0;
      start = 1'b0;
      chk_i("clear_start_busy", int'(busy), 0);
      chk("clear_start_weights", weight_bus, '0);
      dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done || busy) dcnt++;
      end
      chk_i("clear_start_no_pass", dcnt, 0);

      // asynchronous reset in the middle of a pass
      @(negedge clk);
      e_in    = 32'd1024;
      ref_bus = taps_all(14'd1);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk_i("pre_reset_busy", int'(busy), 1);
      rstn = 1'b0;
      #1;
      chk("async_reset_weights", weight_bus, '0);
      chk_i("async_reset_busy", int'(busy), 0);
      chk_i("async_reset_done", int'(done), 0);
      @(negedge clk);
      rstn = 1'b1;
      run_pass("after_reset", 32'(-1), taps1(5, 14'd1), wts1(5, 32'(-1)), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
